// File: rtl/led_matrix_switch_ctrl.sv
// led_matrix_switch_ctrl: button conditioning for LEDMatrixAB_m swA/swB.
// Per channel: 2-flop sync, debounce filter, press/release/long-press FSM.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   swA_raw   raw button A pin (async to clk)
//   swB_raw   raw button B pin (async to clk)
//   swA/swB   debounced levels, pressed = 1
//   pressA/B  1-cycle pulse on level 0->1
//   releaseA/B 1-cycle pulse on level 1->0
//   longA/B   1-cycle pulse once per hold, LONG_CYCLES after press
//   combo     1-cycle pulse: both levels high and one rose this cycle
//
// All outputs are registered. Event pulses share the edge on which
// the level output first shows its new value.

module led_matrix_switch_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] LONG_CYCLES     = 24'd5000000,
  parameter logic        ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic swA_raw,
  input  logic swB_raw,
  output logic swA,
  output logic swB,
  output logic pressA,
  output logic pressB,
  output logic releaseA,
  output logic releaseB,
  output logic longA,
  output logic longB,
  output logic combo
);

  localparam int DBW = (DEBOUNCE_CYCLES > 16'd2)
                     ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HCW = $clog2(32'(LONG_CYCLES) + 32'd1);

  localparam logic [DBW-1:0] DB_LAST =
    DBW'(DEBOUNCE_CYCLES - 16'd1);
  localparam logic [HCW-1:0] HOLD_LAST =
    HCW'(LONG_CYCLES - 24'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } state_e;

  // Channel 0 = A, channel 1 = B.
  logic [1:0] pin;
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;

  logic [1:0] level_q;
  logic [1:0] level_d;
  logic [DBW-1:0] db_cnt_q [2];
  logic [DBW-1:0] db_cnt_d [2];

  logic [1:0] rise;
  logic [1:0] fall;

  state_e state_q [2];
  state_e state_d [2];
  logic [HCW-1:0] hold_q [2];
  logic [HCW-1:0] hold_d [2];

  logic [1:0] press_q;
  logic [1:0] press_d;
  logic [1:0] rel_q;
  logic [1:0] rel_d;
  logic [1:0] long_q;
  logic [1:0] long_d;
  logic combo_q;
  logic combo_d;

  assign pin = {swB_raw, swA_raw};

  // Debounce: a differing sample run of DEBOUNCE_CYCLES flips the
  // level; any agreeing sample restarts the run.
  always_comb begin
    level_d = level_q;
    for (int c = 0; c < 2; c++) begin
      db_cnt_d[c] = db_cnt_q[c];
      if (sync2_q[c] == level_q[c]) begin
        db_cnt_d[c] = '0;
      end else if (db_cnt_q[c] == DB_LAST) begin
        level_d[c]  = sync2_q[c];
        db_cnt_d[c] = '0;
      end else if (db_cnt_q[c] != '1) begin
        db_cnt_d[c] = db_cnt_q[c] + DBW'(1);
      end
    end
  end

  // The FSM looks at the next level so its pulses line up with the
  // level register update.
  assign rise = level_d & ~level_q;
  assign fall = level_q & ~level_d;

  always_comb begin
    press_d = '0;
    rel_d   = '0;
    long_d  = '0;
    for (int c = 0; c < 2; c++) begin
      state_d[c] = state_q[c];
      hold_d[c]  = hold_q[c];
      unique case (state_q[c])
        IDLE: begin
          if (rise[c]) begin
            state_d[c] = HELD;
            press_d[c] = 1'b1;
            hold_d[c]  = '0;
          end
        end
        HELD: begin
          if (fall[c]) begin
            state_d[c] = IDLE;
            rel_d[c]   = 1'b1;
          end else begin
            if (hold_q[c] == HOLD_LAST) begin
              state_d[c] = LONG;
              long_d[c]  = 1'b1;
            end
            if (hold_q[c] != '1) begin
              hold_d[c] = hold_q[c] + HCW'(1);
            end
          end
        end
        LONG: begin
          if (fall[c]) begin
            state_d[c] = IDLE;
            rel_d[c]   = 1'b1;
          end
        end
        default: begin
          state_d[c] = IDLE;
        end
      endcase
    end
  end

  assign combo_d = level_d[0] & level_d[1] & (|press_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      long_q  <= '0;
      combo_q <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        db_cnt_q[c] <= '0;
        hold_q[c]   <= '0;
        state_q[c]  <= IDLE;
      end
    end else begin
      sync1_q <= pin ^ {2{ACTIVE_LOW}};
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      combo_q <= combo_d;
      for (int c = 0; c < 2; c++) begin
        db_cnt_q[c] <= db_cnt_d[c];
        hold_q[c]   <= hold_d[c];
        state_q[c]  <= state_d[c];
      end
    end
  end

  assign swA      = level_q[0];
  assign swB      = level_q[1];
  assign pressA   = press_q[0];
  assign pressB   = press_q[1];
  assign releaseA = rel_q[0];
  assign releaseB = rel_q[1];
  assign longA    = long_q[0];
  assign longB    = long_q[1];
  assign combo    = combo_q;

endmodule

// File: tb/tb_led_matrix_switch_ctrl.sv
// tb_led_matrix_switch_ctrl: scoreboard bench for led_matrix_switch_ctrl.
// Events are coded as cycle*16 + kind and matched in order.

module tb_led_matrix_switch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0;
  logic b = 1'b0;
  logic ala = 1'b1;
  logic alb = 1'b1;

  logic swA, swB, pressA, pressB;
  logic releaseA, releaseB, longA, longB, combo;
  logic al_swA, al_swB, al_pressA, al_pressB;
  logic al_relA, al_relB, al_longA, al_longB, al_combo;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int obs_q[$];

  led_matrix_switch_ctrl #(
    .DEBOUNCE_CYCLES(16'd4),
    .LONG_CYCLES(24'd16),
    .ACTIVE_LOW(1'b0)
  ) u_dut (
    .clk(clk), .rst(rst),
    .swA_raw(a), .swB_raw(b),
    .swA(swA), .swB(swB),
    .pressA(pressA), .pressB(pressB),
    .releaseA(releaseA), .releaseB(releaseB),
    .longA(longA), .longB(longB),
    .combo(combo)
  );

  led_matrix_switch_ctrl #(
    .DEBOUNCE_CYCLES(16'd4),
    .LONG_CYCLES(24'd16),
    .ACTIVE_LOW(1'b1)
  ) u_al (
    .clk(clk), .rst(rst),
    .swA_raw(ala), .swB_raw(alb),
    .swA(al_swA), .swB(al_swB),
    .pressA(al_pressA), .pressB(al_pressB),
    .releaseA(al_relA), .releaseB(al_relB),
    .longA(al_longA), .longB(al_longB),
    .combo(al_combo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Kinds: 0 pA 1 pB 2 rA 3 rB 4 lA 5 lB 6 combo
  //        7 al pA 8 al rA 9 al lA 10 al pB 11 al combo
  always @(negedge clk) begin
    if (pressA)    obs_q.push_back(cyc*16 + 0);
    if (pressB)    obs_q.push_back(cyc*16 + 1);
    if (releaseA)  obs_q.push_back(cyc*16 + 2);
    if (releaseB)  obs_q.push_back(cyc*16 + 3);
    if (longA)     obs_q.push_back(cyc*16 + 4);
    if (longB)     obs_q.push_back(cyc*16 + 5);
    if (combo)     obs_q.push_back(cyc*16 + 6);
    if (al_pressA) obs_q.push_back(cyc*16 + 7);
    if (al_relA)   obs_q.push_back(cyc*16 + 8);
    if (al_longA)  obs_q.push_back(cyc*16 + 9);
    if (al_pressB) obs_q.push_back(cyc*16 + 10);
    if (al_combo)  obs_q.push_back(cyc*16 + 11);
  end

  task automatic test_reset();
    int r, e, o;
    rst = 1'b0;
    a = 1'b1;
    b = 1'b1;
    repeat (10) begin
      @(negedge clk);
      tests++;
      if ({swA, swB, pressA, pressB, releaseA, releaseB,
           longA, longB, combo} !== 9'b0) begin
        fails++;
        $display("FAIL reset_outs: got %b want 0",
          {swA, swB, pressA, pressB, releaseA, releaseB,
           longA, longB, combo});
      end
    end
    obs_q.delete();
    r = cyc;
    rst = 1'b1;
    exp_q.push_back((r+6)*16 + 0);
    exp_q.push_back((r+6)*16 + 1);
    exp_q.push_back((r+6)*16 + 6);
    exp_q.push_back((r+12)*16 + 2);
    exp_q.push_back((r+12)*16 + 3);
    repeat (5) @(negedge clk);
    tests++;
    if (swA !== 1'b0) begin
      fails++;
      $display("FAIL reset_early_swA: got %b want 0", swA);
    end
    @(negedge clk);
    tests++;
    if (swA !== 1'b1) begin
      fails++;
      $display("FAIL reset_swA: got %b want 1", swA);
    end
    a = 1'b0;
    b = 1'b0;
    repeat (14) @(negedge clk);
    exp_q.sort();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL reset_ev: got %0d/%0d want %0d/%0d",
          o/16, o%16, e/16, e%16);
      end
    end
    tests++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL reset_extra: got %0d events want 0",
        obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_glitch();
    int n, e, o;
    @(negedge clk);
    n = cyc;
    a = 1'b1;
    repeat (3) @(negedge clk);
    a = 1'b0;
    repeat (10) begin
      @(negedge clk);
      tests++;
      if (swA !== 1'b0) begin
        fails++;
        $display("FAIL glitch_swA: got %b want 0", swA);
      end
    end
    n = cyc;
    a = 1'b1;
    exp_q.push_back((n+6)*16 + 0);
    exp_q.push_back((n+10)*16 + 2);
    repeat (4) @(negedge clk);
    a = 1'b0;
    @(negedge clk);
    tests++;
    if (swA !== 1'b0) begin
      fails++;
      $display("FAIL held4_early: got %b want 0", swA);
    end
    @(negedge clk);
    tests++;
    if (swA !== 1'b1) begin
      fails++;
      $display("FAIL held4_swA: got %b want 1", swA);
    end
    repeat (10) @(negedge clk);
    exp_q.sort();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL glitch_ev: got %0d/%0d want %0d/%0d",
          o/16, o%16, e/16, e%16);
      end
    end
    tests++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL glitch_extra: got %0d events want 0",
        obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_bounce();
    int n, e, o;
    @(negedge clk);
    n = cyc;
    for (int i = 0; i < 10; i++) begin
      a = (i % 2 == 0);
      @(negedge clk);
    end
    a = 1'b1;
    exp_q.push_back((n+16)*16 + 0);
    exp_q.push_back((n+22)*16 + 2);
    repeat (5) @(negedge clk);
    tests++;
    if (swA !== 1'b0) begin
      fails++;
      $display("FAIL bounce_early: got %b want 0", swA);
    end
    @(negedge clk);
    tests++;
    if (swA !== 1'b1) begin
      fails++;
      $display("FAIL bounce_swA: got %b want 1", swA);
    end
    a = 1'b0;
    repeat (14) @(negedge clk);
    exp_q.sort();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL bounce_ev: got %0d/%0d want %0d/%0d",
          o/16, o%16, e/16, e%16);
      end
    end
    tests++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL bounce_extra: got %0d events want 0",
        obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_long();
    int n, e, o;
    @(negedge clk);
    n = cyc;
    a = 1'b1;
    exp_q.push_back((n+6)*16 + 0);
    exp_q.push_back((n+22)*16 + 4);
    exp_q.push_back((n+52)*16 + 2);
    repeat (22) @(negedge clk);
    tests++;
    if ({swA, longA} !== 2'b11) begin
      fails++;
      $display("FAIL long_pulse: got %b want 11", {swA, longA});
    end
    repeat (24) @(negedge clk);
    a = 1'b0;
    repeat (14) @(negedge clk);
    exp_q.sort();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL long_ev: got %0d/%0d want %0d/%0d",
          o/16, o%16, e/16, e%16);
      end
    end
    tests++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL long_extra: got %0d events want 0",
        obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_combo();
    int n, m, e, o;
    @(negedge clk);
    n = cyc;
    a = 1'b1;
    b = 1'b1;
    exp_q.push_back((n+6)*16 + 0);
    exp_q.push_back((n+6)*16 + 1);
    exp_q.push_back((n+6)*16 + 6);
    exp_q.push_back((n+14)*16 + 2);
    exp_q.push_back((n+14)*16 + 3);
    repeat (8) @(negedge clk);
    a = 1'b0;
    b = 1'b0;
    repeat (12) @(negedge clk);
    m = cyc;
    a = 1'b1;
    exp_q.push_back((m+6)*16 + 0);
    exp_q.push_back((m+16)*16 + 1);
    exp_q.push_back((m+16)*16 + 6);
    exp_q.push_back((m+22)*16 + 4);
    exp_q.push_back((m+26)*16 + 2);
    exp_q.push_back((m+26)*16 + 3);
    repeat (10) @(negedge clk);
    b = 1'b1;
    repeat (10) @(negedge clk);
    a = 1'b0;
    b = 1'b0;
    repeat (14) @(negedge clk);
    exp_q.sort();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL combo_ev: got %0d/%0d want %0d/%0d",
          o/16, o%16, e/16, e%16);
      end
    end
    tests++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL combo_extra: got %0d events want 0",
        obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_active_low_reset();
    int n, r, e, o;
    @(negedge clk);
    n = cyc;
    a = 1'b1;
    ala = 1'b0;
    exp_q.push_back((n+6)*16 + 0);
    exp_q.push_back((n+6)*16 + 7);
    repeat (6) @(negedge clk);
    tests++;
    if (al_swA !== 1'b1) begin
      fails++;
      $display("FAIL al_swA: got %b want 1", al_swA);
    end
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if ({swA, al_swA} !== 2'b00) begin
      fails++;
      $display("FAIL async_rst: got %b want 00", {swA, al_swA});
    end
    repeat (3) @(negedge clk);
    r = cyc;
    rst = 1'b1;
    exp_q.push_back((r+6)*16 + 0);
    exp_q.push_back((r+6)*16 + 7);
    exp_q.push_back((r+14)*16 + 2);
    exp_q.push_back((r+14)*16 + 8);
    repeat (8) @(negedge clk);
    a = 1'b0;
    ala = 1'b1;
    repeat (14) @(negedge clk);
    exp_q.sort();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL alrst_ev: got %0d/%0d want %0d/%0d",
          o/16, o%16, e/16, e%16);
      end
    end
    tests++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL alrst_extra: got %0d events want 0",
        obs_q.size());
    end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_bounce();
    test_long();
    test_combo();
    test_active_low_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
